// File: rtl/spi_request_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// spi_sched_pkg
// Shared definitions for the SPI request scheduler:
//   - default byte width and FSM state-register width
//   - FSM state encodings (unlisted encodings recover to IDLE in the top)
// ---------------------------------------------------------------------------
package spi_sched_pkg;

  localparam int DATAWIDTH_BUS_DEF = 8;
  localparam int STATE_SIZE_DEF    = 3;

  typedef enum logic [STATE_SIZE_DEF-1:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5,
    DONE      = 3'd6
  } sched_state_e;

endpackage

// File: rtl/spi_request_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req starting one position above
// the last served index, wrapping, and returns the first set bit.
// Ports:
//   req   in  NUM_REQ    request levels
//   last  in  REQ_IDX_W  index served most recently
//   vld   out 1          at least one request present
//   idx   out REQ_IDX_W  selected requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] last,
  output logic                 vld,
  output logic [REQ_IDX_W-1:0] idx
);

  always_comb begin
    int k;
    vld = 1'b0;
    idx = '0;
    k   = 0;
    // Offset 1 first, offset NUM_REQ (the last-served index itself) last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last) + i) % NUM_REQ;
      if (!vld && req[k]) begin
        vld = 1'b1;
        idx = REQ_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/spi_request_scheduler.sv
// ---------------------------------------------------------------------------
// spi_request_scheduler
// Round-robin scheduler in front of an SPI master. Grants one requester at a
// time, latches its byte, issues a one-cycle start, follows the master busy
// handshake to completion, pulses done on the granted bit and keeps a
// wrapping count of completed transfers.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   defined   -> watchdog aborts a transfer after TIMEOUT_CYCLES clocks in
//                WAIT_BUSY/WAIT_DONE, pulsing error_o with done_o (not counted)
//   undefined -> no watchdog, error_o tied to 0
//
// Ports:
//   PULSE_COUNTER_CLOCK_50      in   clock, rising edge
//   PULSE_COUNTER_RESET_InHigh  in   async active-high reset
//   req_i                       in   per-requester request level
//   data_i                      in   flattened request bytes (k at [k*W +: W])
//   master_busy_i               in   SPI master busy
//   master_start_o              out  one-cycle start pulse
//   master_data_o               out  byte for the master
//   grant_o                     out  one-hot grant, zero when idle
//   done_o                      out  one-cycle completion pulse
//   error_o                     out  one-cycle watchdog abort pulse
//   xfer_count_o                out  completed-transfer count (wraps)
// ---------------------------------------------------------------------------
module spi_request_scheduler
  import spi_sched_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_BUS_DEF,
  parameter int NUM_REQ        = 4,
  parameter int REQ_IDX_W      = 2,
  parameter int STATE_SIZE     = STATE_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                             PULSE_COUNTER_CLOCK_50,
  input  logic                             PULSE_COUNTER_RESET_InHigh,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0] data_i,
  input  logic                             master_busy_i,
  output logic                             master_start_o,
  output logic [DATAWIDTH_BUS-1:0]         master_data_o,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [NUM_REQ-1:0]               done_o,
  output logic                             error_o,
  output logic [DATAWIDTH_BUS-1:0]         xfer_count_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || REQ_IDX_W != $clog2(NUM_REQ) ||
      STATE_SIZE != STATE_SIZE_DEF || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("spi_request_scheduler: illegal parameter combination");
  end

  sched_state_e           state_q;
  logic [REQ_IDX_W-1:0]   last_q;
  logic [REQ_IDX_W-1:0]   idx_q;
  logic                   arb_vld;
  logic [REQ_IDX_W-1:0]   arb_idx;
  logic                   timeout_hit;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_rr_arbiter (
    .req  (req_i),
    .last (last_q),
    .vld  (arb_vld),
    .idx  (arb_idx)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            abort;
  logic            error_q;

  // Counter is 0 in the first WAIT_BUSY cycle, so the abort edge lands
  // exactly TIMEOUT_CYCLES clocks after entering WAIT_BUSY. ">=" keeps the
  // abort armed if the limit is reached on the WAIT_BUSY->WAIT_DONE edge.
  assign timeout_hit = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));
  assign abort = timeout_hit &&
                 (((state_q == WAIT_BUSY) && !master_busy_i) ||
                  ((state_q == WAIT_DONE) &&  master_busy_i));

  always_ff @(posedge PULSE_COUNTER_CLOCK_50 or posedge PULSE_COUNTER_RESET_InHigh) begin
    if (PULSE_COUNTER_RESET_InHigh) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= abort;
      if (state_q == START) begin
        to_cnt_q <= '0;
      end else if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && !timeout_hit) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign error_o = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

  always_ff @(posedge PULSE_COUNTER_CLOCK_50 or posedge PULSE_COUNTER_RESET_InHigh) begin
    if (PULSE_COUNTER_RESET_InHigh) begin
      state_q        <= IDLE;
      last_q         <= REQ_IDX_W'(NUM_REQ - 1);
      idx_q          <= '0;
      master_start_o <= 1'b0;
      master_data_o  <= '0;
      grant_o        <= '0;
      done_o         <= '0;
      xfer_count_o   <= '0;
    end else begin
      master_start_o <= 1'b0;
      done_o         <= '0;
      case (state_q)
        IDLE: begin
          if (|req_i) state_q <= ARB;
        end
        // Grant is committed here; later req_i/data_i changes are ignored.
        ARB: begin
          if (arb_vld) begin
            idx_q         <= arb_idx;
            grant_o       <= NUM_REQ'(1) << arb_idx;
            master_data_o <= data_i[int'(arb_idx)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            state_q       <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          master_start_o <= 1'b1;
          state_q        <= START;
        end
        START: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (master_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timeout_hit) begin
            done_o  <= grant_o;
            last_q  <= idx_q;
            state_q <= DONE;
          end
        end
        // done_o is registered on the exit edge so it is high during DONE.
        WAIT_DONE: begin
          if (!master_busy_i) begin
            done_o       <= grant_o;
            xfer_count_o <= xfer_count_o + 1'b1;
            last_q       <= idx_q;
            state_q      <= DONE;
          end else if (timeout_hit) begin
            done_o  <= grant_o;
            last_q  <= idx_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          grant_o <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_o <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spi_request_scheduler
// Directed bench for spi_request_scheduler with a simple SPI master model
// that answers each start pulse with a configurable busy window.
// ---------------------------------------------------------------------------
module tb_spi_request_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        busy;
  logic        master_start_o;
  logic [7:0]  master_data_o;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic        error_o;
  logic [7:0]  xfer_count_o;

  int checks   = 0;
  int failures = 0;

  int busy_delay = 5;
  int busy_len   = 3;
  int start_cnt  = 0;
  bit model_en   = 1'b1;

  always #5 clk = ~clk;

  spi_request_scheduler #(
    .DATAWIDTH_BUS  (8),
    .NUM_REQ        (4),
    .REQ_IDX_W      (2),
    .STATE_SIZE     (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PULSE_COUNTER_CLOCK_50     (clk),
    .PULSE_COUNTER_RESET_InHigh (rst),
    .req_i                      (req),
    .data_i                     (data),
    .master_busy_i              (busy),
    .master_start_o             (master_start_o),
    .master_data_o              (master_data_o),
    .grant_o                    (grant_o),
    .done_o                     (done_o),
    .error_o                    (error_o),
    .xfer_count_o               (xfer_count_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI master model: counts start pulses and answers with a busy window.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (master_start_o) begin
        start_cnt++;
        if (model_en) begin
          repeat (busy_delay) @(negedge clk);
          busy = 1'b1;
          repeat (busy_len) @(negedge clk);
          busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_grant"}, grant_o, 0);
    chk_eq({tag, "_done"},  done_o, 0);
    chk_eq({tag, "_start"}, master_start_o, 0);
    chk_eq({tag, "_data"},  master_data_o, 0);
    chk_eq({tag, "_cnt"},   xfer_count_o, 0);
    chk_eq({tag, "_err"},   error_o, 0);
  endtask

  // One full transfer: grant, one start, done pulse, count, grant release.
  task automatic xfer(input string tag, input int exp_idx, input logic [7:0] exp_data,
                      input logic [7:0] exp_cnt);
    int s0;
    bit seen;
    s0   = start_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (grant_o != 0) seen = 1'b1;
    end
    chk_eq({tag, "_grant_seen"}, seen, 1);
    chk_eq({tag, "_grant"}, grant_o, 32'(4'b0001 << exp_idx));
    chk_eq({tag, "_data"},  master_data_o, exp_data);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o != 0) seen = 1'b1;
    end
    chk_eq({tag, "_done_seen"}, seen, 1);
    chk_eq({tag, "_done"},  done_o, 32'(4'b0001 << exp_idx));
    chk_eq({tag, "_cnt"},   xfer_count_o, exp_cnt);
    chk_eq({tag, "_hold"},  master_data_o, exp_data);
    chk_eq({tag, "_starts"}, start_cnt - s0, 1);
    chk_eq({tag, "_err"},   error_o, 0);
    @(negedge clk);
    chk_eq({tag, "_done_off"},  done_o, 0);
    chk_eq({tag, "_grant_off"}, grant_o, 0);
  endtask

  initial begin
    bit seen;
    int s0;
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_rel");

    // Single request, exact first-transaction timing
    busy_delay = 5;
    busy_len   = 3;
    data = 32'h4433A511;
    req  = 4'b0010;
    @(negedge clk);
    chk_eq("t1_e0_grant", grant_o, 0);
    @(negedge clk);
    chk_eq("t1_e1_grant", grant_o, 4'b0010);
    chk_eq("t1_e1_data",  master_data_o, 8'hA5);
    chk_eq("t1_e1_start", master_start_o, 0);
    @(negedge clk);
    chk_eq("t1_e2_start", master_start_o, 1);
    @(negedge clk);
    chk_eq("t1_e3_start", master_start_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o != 0) seen = 1'b1;
    end
    chk_eq("t1_done_seen", seen, 1);
    chk_eq("t1_done",  done_o, 4'b0010);
    chk_eq("t1_cnt",   xfer_count_o, 1);
    chk_eq("t1_data",  master_data_o, 8'hA5);
    chk_eq("t1_starts", start_cnt, 1);
    req = 4'b0000;
    @(negedge clk);
    chk_eq("t1_done_off", done_o, 0);
    chk_eq("t1_grant_off", grant_o, 0);

    // Continuous requests from all four, busy already high in START
    do_reset();
    busy_delay = 0;
    busy_len   = 2;
    data = 32'h44332211;
    req  = 4'b1111;
    xfer("rr0", 0, 8'h11, 8'd1);
    xfer("rr1", 1, 8'h22, 8'd2);
    xfer("rr2", 2, 8'h33, 8'd3);
    xfer("rr3", 3, 8'h44, 8'd4);
    xfer("rr4", 0, 8'h11, 8'd5);
    req = 4'b0000;
    repeat (6) @(negedge clk);

    // Requester drops req and changes data after its grant
    busy_delay = 3;
    busy_len   = 3;
    req = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (grant_o != 0) seen = 1'b1;
    end
    chk_eq("t3_grant_seen", seen, 1);
    chk_eq("t3_grant", grant_o, 4'b0100);
    req  = 4'b0000;
    data = 32'h44FF2211;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o != 0) seen = 1'b1;
    end
    chk_eq("t3_done_seen", seen, 1);
    chk_eq("t3_done", done_o, 4'b0100);
    chk_eq("t3_data", master_data_o, 8'h33);
    chk_eq("t3_cnt",  xfer_count_o, 6);
    // Request seen in IDLE, gone by ARB: back to IDLE with no transfer
    @(negedge clk);
    s0  = start_cnt;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    repeat (6) begin
      @(negedge clk);
      chk_eq("t3_empty_arb_grant", grant_o, 0);
    end
    chk_eq("t3_empty_arb_starts", start_cnt - s0, 0);

    // Reset during WAIT_DONE
    data       = 32'h44332211;
    busy_delay = 0;
    busy_len   = 20;
    req = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk_eq("t5_busy_seen", seen, 1);
    chk_eq("t5_grant", grant_o, 4'b1000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk);
    chk_all_zero("t5_rst");
    rst = 1'b0;
    req = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    chk_eq("t5_busy_clear", seen, 1);
    busy_len = 2;
    req = 4'b1001;
    xfer("t5_next", 0, 8'h11, 8'd1);
    req = 4'b0000;

    // Count wrap: 256 transfers, round-robin throughout
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 256; n++) begin
      xfer("wrap", n % 4, 8'(data >> (8 * (n % 4))), 8'(n + 1));
    end
    chk_eq("wrap_final", xfer_count_o, 0);
    req = 4'b0000;
    repeat (6) @(negedge clk);

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: master never raises busy
    do_reset();
    model_en = 1'b0;
    req = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (master_start_o) seen = 1'b1;
    end
    chk_eq("to_start_seen", seen, 1);
    req = 4'b0000;
    repeat (16) @(negedge clk);
    chk_eq("to_early_err",  error_o, 0);
    chk_eq("to_early_done", done_o, 0);
    @(negedge clk);
    chk_eq("to_err",  error_o, 1);
    chk_eq("to_done", done_o, 4'b0001);
    chk_eq("to_cnt",  xfer_count_o, 0);
    @(negedge clk);
    chk_eq("to_err_off", error_o, 0);
    model_en = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_request_scheduler.md
# spi_request_scheduler

Round-robin transfer scheduler in front of the SPI master. Up to NUM_REQ client blocks each present one byte with a request. The scheduler grants one requester at a time, loads its byte into the master, and issues a one-cycle start. It then tracks the master busy handshake to completion, returns a per-requester done pulse, and keeps a wrapping count of completed transfers.

## Interface
- DATAWIDTH_BUS, 8: byte width of each request and of the master data path.
- NUM_REQ, 4: number of requesters (2..8).
- REQ_IDX_W, 2: index width; must equal clog2(NUM_REQ).
- STATE_SIZE, 3: FSM state register width.
- TIMEOUT_CYCLES, 1023: watchdog limit in clocks (used only with SCHED_TIMEOUT_EN).

Ports:
- PULSE_COUNTER_CLOCK_50  in  1  system clock; all logic is rising-edge.
- PULSE_COUNTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- req_i  in  NUM_REQ  per-requester request level.
- data_i  in  NUM_REQ*DATAWIDTH_BUS  flattened bytes; requester k occupies bits [k*DATAWIDTH_BUS +: DATAWIDTH_BUS].
- master_busy_i  in  1  SPI master busy.
- master_start_o  out  1  one-cycle start pulse to the master.
- master_data_o  out  DATAWIDTH_BUS  byte for the master; held stable from LOAD through DONE.
- grant_o  out  NUM_REQ  one-hot grant; zero when no transfer is active.
- done_o  out  NUM_REQ  one-cycle completion pulse on the granted bit.
- error_o  out  1  one-cycle watchdog abort pulse.
- xfer_count_o  out  DATAWIDTH_BUS  completed-transfer count.

## Operation
- All outputs are registered.
- Reset value of every output is 0. After reset the state is IDLE and the round-robin pointer last_q = NUM_REQ-1, so requester 0 has first priority.
- FSM transitions:
  - IDLE: if any req_i bit is set, go to ARB.
  - ARB: search from last_q+1 upward, wrapping. On the first set bit, latch idx, set grant_o[idx], latch master_data_o = data_i[idx], and go to LOAD. If req_i is all zero, return to IDLE.
  - LOAD: go to START; master_start_o is registered high on this edge.
  - START: master_start_o returns to 0; go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when master_busy_i = 1.
  - WAIT_DONE: go to DONE when master_busy_i = 0.
  - DONE: pulse done_o[idx], increment xfer_count_o, set last_q = idx, clear grant_o, go to IDLE.
- Handshake rules:
  - Requesters hold req_i and data_i until their done_o pulse.
  - A grant is committed: dropping req_i after ARB does not abort the transfer.
  - data_i changes after ARB are ignored.
- master_busy_i already high during START: WAIT_BUSY exits on the next edge; no extra cycle is required.
- xfer_count_o wraps from 2^DATAWIDTH_BUS-1 to 0 with no flag.
- All NUM_REQ requesting continuously: service order is 0,1,2,...,NUM_REQ-1,0,...
- Reset mid-transfer: all outputs clear immediately. An in-flight master operation is abandoned and not counted.

## Timing
- Request sampled in IDLE at edge E0 → ARB. grant_o and master_data_o are valid after E1. master_start_o is high from E2 to E3.
- Minimum cycle from one DONE to the next start is 3 clocks: IDLE, ARB, LOAD.
- done_o is asserted for exactly the cycle after the WAIT_DONE exit edge.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_BUSY and runs through WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE. error_o pulses together with done_o[idx], and xfer_count_o is not incremented.
- SCHED_TIMEOUT_EN undefined: no counter is built, the FSM waits indefinitely, and error_o is tied to 0.

## Structure
- Package spi_sched_pkg holds:
  - State encodings: IDLE=0, ARB=1, LOAD=2, START=3, WAIT_BUSY=4, WAIT_DONE=5, DONE=6; any other encoding recovers to IDLE.
  - DATAWIDTH_BUS and STATE_SIZE defaults.
- Sub-module rr_arbiter: combinational. Inputs req and last pointer; outputs a valid flag and the next index.
- The FSM, data latch and counters live in the top module.

## Test plan
- Single request: req_i=4'b0010, data_i byte1=8'hA5, master_busy_i high 5 cycles after start → grant_o=0010, master_data_o=A5, one start pulse, done_o=0010, xfer_count_o=1.
- Continuous request from all four → grants 0,1,2,3,0 in order; xfer_count_o=5 after five completions.
- Requester drops req_i after grant → transfer still completes with done_o; the next ARB with no request returns to IDLE.
- Preload xfer_count_o to 255 with 255 transfers, then one more → xfer_count_o=0.
- Assert reset during WAIT_DONE → all outputs 0 next cycle; next grant goes to requester 0.
- With SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, master_busy_i stuck 0 → error_o and done_o pulse together 16 cycles after entering WAIT_BUSY; count unchanged.
